// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the sync_fifo_rv block.
//   ptr_width()  : pointer width for a given depth (address bits plus one wrap bit)
//   is_pow2()    : legality test for the DEPTH parameter
//   ptr_t        : read/write pointer type for the default depth
package sync_fifo_pkg;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int unsigned depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

  localparam int unsigned DefaultDepth = 4;
  localparam int unsigned PtrW         = ptr_width(DefaultDepth);

  typedef logic [PtrW-1:0] ptr_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
// Contents are never reset; validity is tracked by the pointers in the parent.
// Ports:
//   clk      rising-edge clock
//   wr_en    write strobe, stores wr_data at wr_addr
//   wr_addr  write address
//   wr_data  write word
//   rd_addr  read address
//   rd_data  word at rd_addr (combinational)
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = DefaultDepth
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  localparam int unsigned AddrW = ptr_width(DEPTH) - 1;

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[AddrW'(rd_addr)];

endmodule

// File: rtl/sync_fifo_rv.sv
// Single-clock FIFO with valid/ready handshakes on both sides, first-word fall-through.
// One write and one read may complete every cycle; order is preserved.
// Optional feature: define SYNC_FIFO_LEVEL_EN to add the `level` occupancy output.
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous, active-high reset
//   wr_data   write word
//   wr_valid  producer offers wr_data
//   wr_ready  FIFO not full
//   rd_data   head-of-queue word (valid while rd_valid)
//   rd_valid  FIFO not empty
//   rd_ready  consumer takes rd_data
//   level     (SYNC_FIFO_LEVEL_EN only) current occupancy, 0..DEPTH
module sync_fifo_rv
  import sync_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = DefaultDepth
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [WIDTH-1:0]               wr_data,
  input  logic                           wr_valid,
  output logic                           wr_ready,
  output logic [WIDTH-1:0]               rd_data,
  output logic                           rd_valid,
  input  logic                           rd_ready
`ifdef SYNC_FIFO_LEVEL_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0]     level
`endif
);

  localparam int unsigned AddrW   = PtrW - 1;
  localparam bit          DepthOk = is_pow2(DEPTH) && (ptr_width(DEPTH) == PtrW);

  // ptr_t is sized for DefaultDepth; reject any depth it cannot address.
  if (!DepthOk) begin : gen_depth_check
    $error("sync_fifo_rv: DEPTH must be a power of two >= 2 matching ptr_t");
  end

  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  logic full, empty;
  logic wr_fire, rd_fire;

  // Extra wrap bit distinguishes full (MSBs differ) from empty (all bits equal).
  assign full  = (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]) &&
                 (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  // Flags depend on pointer registers only, never on the handshake inputs.
  assign wr_ready = ~full;
  assign rd_valid = ~empty;

  assign wr_fire = wr_valid & wr_ready;
  assign rd_fire = rd_valid & rd_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_fire) begin
      wr_ptr_d = wr_ptr_q + ptr_t'(1);
    end
    if (rd_fire) begin
      rd_ptr_d = rd_ptr_q + ptr_t'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  sync_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_fire),
    .wr_addr (wr_ptr_q[AddrW-1:0]),
    .wr_data (wr_data),
    .rd_addr (rd_ptr_q[AddrW-1:0]),
    .rd_data (rd_data)
  );

`ifdef SYNC_FIFO_LEVEL_EN
  localparam int unsigned LevelW = $clog2(DEPTH + 1);

  logic [LevelW-1:0] level_q, level_d;

  always_comb begin
    level_d = level_q;
    case ({wr_fire, rd_fire})
      2'b10:   level_d = level_q + LevelW'(1);
      2'b01:   level_d = level_q - LevelW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q <= '0;
    end else begin
      level_q <= level_d;
    end
  end

  assign level = level_q;
`endif

endmodule

// File: tb/tb_sync_fifo_rv.sv
// Directed bench for sync_fifo_rv. Write data comes from an xorshift32 generator that
// advances per write transfer; a second identically seeded generator advancing per read
// transfer supplies the expected rd_data. An occupancy model predicts the flags.
module tb_sync_fifo_rv;

  localparam int unsigned Depth = 4;
  localparam logic [31:0] Seed  = 32'h1234_5678;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_ready;
`ifdef SYNC_FIFO_LEVEL_EN
  logic [2:0]  level;
`endif

  int          checks = 0;
  int          errors = 0;
  int          cnt    = 0;
  int          reads  = 0;
  logic [31:0] wr_prng;
  logic [31:0] rd_prng;
  logic [31:0] pat_w;
  logic [31:0] pat_r;

  always #5 clk = ~clk;

  sync_fifo_rv #(
    .WIDTH (32),
    .DEPTH (Depth)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_data  (wr_data),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready)
`ifdef SYNC_FIFO_LEVEL_EN
    ,
    .level    (level)
`endif
  );

  function automatic logic [31:0] xs(input logic [31:0] x);
    logic [31:0] y;
    y = x;
    y = y ^ (y << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_flags();
    check("rd_valid", 32'(rd_valid), 32'(cnt != 0));
    check("wr_ready", 32'(wr_ready), 32'(cnt < int'(Depth)));
`ifdef SYNC_FIFO_LEVEL_EN
    check("level", 32'(level), 32'(cnt));
`endif
  endtask

  // One cycle: drive inputs, check outputs, clock, update model, settle 1 time unit.
  task automatic step(input logic wv, input logic rr);
    logic wf;
    logic rf;
    wr_valid = wv;
    rd_ready = rr;
    wr_data  = wr_prng;
    wf = wv && (cnt < int'(Depth));
    rf = rr && (cnt != 0);
    check_flags();
    if (rf) check("rd_data", rd_data, rd_prng);
    @(posedge clk);
    if (wf) begin
      wr_prng = xs(wr_prng);
      cnt++;
    end
    if (rf) begin
      rd_prng = xs(rd_prng);
      cnt--;
      reads++;
    end
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    wr_data  = '0;
    wr_prng  = Seed;
    rd_prng  = Seed;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    check("reset_wr_ready", 32'(wr_ready), 32'd1);
    check("reset_rd_valid", 32'(rd_valid), 32'd0);
`ifdef SYNC_FIFO_LEVEL_EN
    check("reset_level", 32'(level), 32'd0);
`endif

    // Fill: six offered writes, only four accepted
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
    check("fill_wr_ready", 32'(wr_ready), 32'd0);
    check("fill_rd_valid", 32'(rd_valid), 32'd1);

    // Drain: four in-order reads, then empty
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
    check("drain_rd_valid", 32'(rd_valid), 32'd0);
    check("drain_wr_ready", 32'(wr_ready), 32'd1);

    // Concurrent at level 2
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    reads = 0;
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1);
    check("concurrent_reads", 32'(reads), 32'd10);
    check("concurrent_rd_valid", 32'(rd_valid), 32'd1);

    // Full plus read: first cycle read only, then one of each per cycle
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("full_wr_ready", 32'(wr_ready), 32'd0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1);
    check("full_read_wr_ready", 32'(wr_ready), 32'd1);

    // Scripted soak
    pat_w = 32'hF7DE_FB7D;
    pat_r = 32'hDBB6_EDB7;
    reads = 0;
    for (int i = 0; i < 320 && reads < 128; i++) begin
      step(pat_w[i % 32], pat_r[(i * 7) % 32]);
    end
    check("soak_reads", 32'(reads), 32'd128);

    // Async reset at level 3, asserted between clock edges
    for (int i = 0; i < 8 && cnt != 0; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    check("pre_reset_rd_valid", 32'(rd_valid), 32'd1);
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    cnt     = 0;
    rd_prng = wr_prng;
    check("async_rd_valid", 32'(rd_valid), 32'd0);
    check("async_wr_ready", 32'(wr_ready), 32'd1);
`ifdef SYNC_FIFO_LEVEL_EN
    check("async_level", 32'(level), 32'd0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
